// File: rtl/fir_decimating_output_buffer.sv
// fir_decimating_output_buffer: keeps one in DECIM filter samples and buffers them in a FWFT FIFO
module fir_decimating_output_buffer #(
    parameter int N     = 16,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [N-1:0]                   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N-1:0]                   out_data,
    output logic [$clog2(DEPTH+1)-1:0]     fill_level,
    output logic                           overflow,
    input  logic                           clear_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;

    logic [PW-1:0] phase_q, phase_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          overflow_q, overflow_d;
    logic [N-1:0]  mem_q [DEPTH];
    logic          keep, pop, push, drop, full;

    // Decimation, push/pop decisions and next-state for pointers, fill and sticky overflow
    always_comb begin
        keep       = in_valid && phase_q == '0;
        pop        = out_valid && out_ready;
        full       = fill_q == FW'(DEPTH);
        push       = keep && (!full || pop);
        drop       = keep && full && !pop;
        phase_d    = !in_valid ? phase_q : phase_q == PW'(DECIM - 1) ? '0 : phase_q + PW'(1);
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        fill_d     = (push && !pop) ? fill_q + FW'(1) : (pop && !push) ? fill_q - FW'(1) : fill_q;
        overflow_d = drop || (overflow_q && !clear_overflow);
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    // Sample storage; contents need no reset since fill level gates visibility
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign out_valid  = fill_q != '0;
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fill_level = fill_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_fir_decimating_output_buffer.sv
// tb_fir_decimating_output_buffer: directed checks of decimation, FIFO buffering, overflow and reset
module tb_fir_decimating_output_buffer;
    logic               clk = 1'b0, reset = 1'b1;
    logic               in_valid = 1'b0, out_ready = 1'b0, clear_overflow = 1'b0;
    logic signed [15:0] in_data = '0;
    logic               valid_a, valid_b, ovf_a, ovf_b;
    logic signed [15:0] data_a, data_b;
    logic [3:0]         fill_a, fill_b;
    int                 n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    fir_decimating_output_buffer #(.N(16), .DECIM(4), .DEPTH(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a),
        .fill_level(fill_a), .overflow(ovf_a), .clear_overflow(clear_overflow));

    fir_decimating_output_buffer #(.N(16), .DECIM(1), .DEPTH(8)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b),
        .fill_level(fill_b), .overflow(ovf_b), .clear_overflow(clear_overflow));

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    initial begin
        tick();
        chk("rst_valid", valid_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_fill", fill_a, 0);
        chk("rst_ovf", ovf_a, 0);
        reset = 1'b0;

        out_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            tick();
            chk("dec_valid", valid_a, (i % 4 == 1) ? 1 : 0);
            chk("dec_data", data_a, (i % 4 == 1) ? i : 0);
        end
        chk("dec_ovf", ovf_a, 0);

        in_valid = 1'b0;
        pulse_reset();
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1;
            in_data  = 16'(10 + j);
            tick();
            chk("gap_valid", valid_a, (j % 4 == 0) ? 1 : 0);
            chk("gap_data", data_a, (j % 4 == 0) ? 10 + j : 0);
            in_valid = 1'b0;
            in_data  = 16'sd99;
            tick();
            chk("gap_idle", valid_a, 0);
        end

        pulse_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(-i);
            tick();
            chk("fill_level", fill_b, i > 8 ? 8 : i);
            chk("fill_ovf", ovf_b, i > 8 ? 1 : 0);
        end
        chk("fill_head", data_b, -1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            chk("drain_valid", valid_b, 1);
            chk("drain_data", data_b, -j);
            tick();
        end
        chk("drain_empty", valid_b, 0);
        chk("drain_zero", data_b, 0);
        chk("drain_fill", fill_b, 0);

        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(100 + i);
            tick();
        end
        chk("full_fill", fill_b, 8);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_data = 16'(108 + c);
            tick();
            chk("pp_fill", fill_b, 8);
            chk("pp_head", data_b, 101 + c);
        end
        chk("pp_ovf", ovf_b, 1);

        out_ready      = 1'b0;
        in_valid       = 1'b0;
        clear_overflow = 1'b1;
        tick();
        chk("clr_alone", ovf_b, 0);
        in_valid = 1'b1;
        in_data  = 16'sd200;
        tick();
        chk("clr_vs_set", ovf_b, 1);
        chk("drop_fill", fill_b, 8);
        chk("drop_head", data_b, 108);
        in_valid = 1'b0;
        tick();
        chk("clr_after", ovf_b, 0);
        clear_overflow = 1'b0;

        pulse_reset();
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            tick();
        end
        chk("pre_rst_fill", fill_b, 5);
        chk("pre_rst_fill_a", fill_a, 2);
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("async_valid", valid_b, 0);
        chk("async_data", data_b, 0);
        chk("async_fill", fill_b, 0);
        chk("async_fill_a", fill_a, 0);
        #1 reset = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'sd77;
        tick();
        chk("post_rst_valid_a", valid_a, 1);
        chk("post_rst_data_a", data_a, 77);
        chk("post_rst_data_b", data_b, 77);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
